// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and helpers for the UART receive path.
// Imported by uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    // Bit period in system clock cycles.
    function automatic int bit_period(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Parity bit a transmitter sends for this data: even (odd=0) or odd.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with wrap-bit pointers.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int Width = 10,
    parameter int Depth = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [Width-1:0]           wdata,
    output logic [Width-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] count
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_wptr == r_rptr);
    assign full   = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign count  = r_wptr - r_rptr;
    assign rdata  = empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // Advance write/read pointers on accepted push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty gates rdata.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with glitch-rejecting start detect,
// optional parity, 1-2 stop bits and an output FIFO with sticky overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int ClockFreqHz  = 10000000,
    parameter int BaudRate     = 9600,
    parameter int DataBitsSize = 8,
    parameter int ParityEn     = 0,
    parameter int ParityOdd    = 0,
    parameter int StopBitsSize = 1,
    parameter int FifoDepth    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx_sig,
    output logic [DataBitsSize-1:0]        rx_data,
    output logic                           rx_perr,
    output logic                           rx_ferr,
    output logic                           rx_valid,
    input  logic                           rx_ready,
    output logic [$clog2(FifoDepth+1)-1:0] fifo_count,
    output logic                           overrun,
    input  logic                           clr_overrun
);

    localparam int P  = bit_period(ClockFreqHz, BaudRate);
    localparam int CW = $clog2(P);
    localparam int DW = DataBitsSize;
    localparam int EW = DW + 2;

    localparam logic [CW-1:0] CntLast  = CW'(P - 1);
    localparam logic [CW-1:0] CntHalf  = CW'(P / 2 - 1);
    localparam logic [2:0]    IdxLast  = 3'(DW - 1);
    localparam logic [2:0]    StopLast = 3'(StopBitsSize - 1);

    logic           r_sync1;
    logic           r_rxs;
    uart_rx_state_e r_state;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_idx;
    logic [DW-1:0]  r_shift;
    logic           r_perr;
    logic           r_ferr;
    logic           r_overrun;

    logic           w_tick;
    logic           w_done;
    logic           w_ferr;
    logic           w_perr;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [EW-1:0]  w_wdata;
    logic [EW-1:0]  w_rdata;

    assign w_tick  = (r_cnt == CntLast);
    assign w_done  = (r_state == STOP) && w_tick && (r_idx == StopLast);
    assign w_ferr  = r_ferr | ~r_rxs;
    assign w_perr  = r_rxs != calc_parity(8'(r_shift), 1'(ParityOdd));
    assign w_wdata = {w_ferr, r_perr, r_shift};
    assign w_pop   = ~w_empty & rx_ready;

    // Two-flop synchronizer; idles high so reset does not look like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx_sig;
            r_rxs   <= r_sync1;
        end
    end

    // Frame FSM: half-bit start check, then one mid-bit sample every P cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!r_rxs) r_state <= START;
                end
                START: begin
                    if (r_cnt == CntHalf) begin
                        r_cnt <= '0;
                        if (r_rxs) begin
                            r_state <= IDLE;
                        end else begin
                            r_idx   <= '0;
                            r_perr  <= 1'b0;
                            r_ferr  <= 1'b0;
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= r_rxs;
                        if (r_idx == IdxLast) begin
                            r_idx   <= '0;
                            r_state <= (ParityEn != 0) ? PARITY : STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_perr  <= w_perr;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_cnt  <= '0;
                        r_ferr <= w_ferr;
                        if (r_idx == StopLast) begin
                            r_idx   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky overrun: a finished frame found the FIFO full with no pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_done && w_full && !w_pop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    sync_fifo #(
        .Width (EW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_done),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    assign rx_data  = w_rdata[DW-1:0];
    assign rx_perr  = w_rdata[DW];
    assign rx_ferr  = w_rdata[DW+1];
    assign rx_valid = ~w_empty;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: three receiver configurations (8N1, 8E1, 7N2) at P = 10,
// directed scenarios plus random frames checked by per-instance scoreboards.
module tb_uart_rx;

    localparam int P = 10;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;
    logic clr = 1'b0;
    logic rxa = 1'b1;
    logic rxb = 1'b1;
    logic rxc = 1'b1;

    logic [7:0] da;
    logic [7:0] db;
    logic [6:0] dc;
    logic       pa, pb, pc;
    logic       fa, fb, fc;
    logic       va, vb, vc;
    logic       oa, ob, oc;
    logic [2:0] ca, cb, cc;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rand_rdy = 1'b0;
    ent_t qa[$];
    ent_t qb[$];
    ent_t qc[$];

    always #5 clk = ~clk;

    uart_rx #(
        .ClockFreqHz(10000000), .BaudRate(1000000), .DataBitsSize(8),
        .ParityEn(0), .ParityOdd(0), .StopBitsSize(1), .FifoDepth(4)
    ) u_a (
        .clk(clk), .rst(rst), .rx_sig(rxa), .rx_data(da), .rx_perr(pa),
        .rx_ferr(fa), .rx_valid(va), .rx_ready(rdy), .fifo_count(ca),
        .overrun(oa), .clr_overrun(clr)
    );

    uart_rx #(
        .ClockFreqHz(10000000), .BaudRate(1000000), .DataBitsSize(8),
        .ParityEn(1), .ParityOdd(0), .StopBitsSize(1), .FifoDepth(4)
    ) u_b (
        .clk(clk), .rst(rst), .rx_sig(rxb), .rx_data(db), .rx_perr(pb),
        .rx_ferr(fb), .rx_valid(vb), .rx_ready(rdy), .fifo_count(cb),
        .overrun(ob), .clr_overrun(clr)
    );

    uart_rx #(
        .ClockFreqHz(10000000), .BaudRate(1000000), .DataBitsSize(7),
        .ParityEn(0), .ParityOdd(0), .StopBitsSize(2), .FifoDepth(4)
    ) u_c (
        .clk(clk), .rst(rst), .rx_sig(rxc), .rx_data(dc), .rx_perr(pc),
        .rx_ferr(fc), .rx_valid(vc), .rx_ready(rdy), .fifo_count(cc),
        .overrun(oc), .clr_overrun(clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int w, input logic v);
        if (w == 0) rxa = v;
        else if (w == 1) rxb = v;
        else rxc = v;
    endtask

    task automatic pop1();
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
    endtask

    // Serialise one frame; expectation comes from counting ones and stop bits.
    task automatic send(input int w, input logic [7:0] d, input logic pbit,
                        input int bad, input bit push);
        int   nb;
        int   ns;
        int   ones;
        bit   pe;
        ent_t e;
        nb   = (w == 2) ? 7 : 8;
        ns   = (w == 2) ? 2 : 1;
        pe   = (w == 1);
        ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(d[i]);
        e.data = d & 8'((1 << nb) - 1);
        e.perr = pe && (((ones + int'(pbit)) % 2) != 0);
        e.ferr = (bad >= 0) && (bad < ns);
        if (push) begin
            if (w == 0) qa.push_back(e);
            else if (w == 1) qb.push_back(e);
            else qc.push_back(e);
        end
        drive(w, 1'b0);
        tick(P);
        for (int i = 0; i < nb; i++) begin
            drive(w, d[i]);
            tick(P);
        end
        if (pe) begin
            drive(w, pbit);
            tick(P);
        end
        for (int s = 0; s < ns; s++) begin
            drive(w, (s == bad) ? 1'b0 : 1'b1);
            tick(P);
        end
        drive(w, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst && va && rdy)
            chk("a_pop", 32'({fa, pa, da}),
                (qa.size() != 0) ? 32'(qa.pop_front()) : 32'hDEAD);
    end

    always @(negedge clk) begin
        if (!rst && vb && rdy)
            chk("b_pop", 32'({fb, pb, db}),
                (qb.size() != 0) ? 32'(qb.pop_front()) : 32'hDEAD);
    end

    always @(negedge clk) begin
        if (!rst && vc && rdy)
            chk("c_pop", 32'({fc, pc, 1'b0, dc}),
                (qc.size() != 0) ? 32'(qc.pop_front()) : 32'hDEAD);
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int nsb;
        logic [7:0] d;

        tick(3);
        rst = 1'b0;
        tick(2);
        chk("rst_a", 32'({va, ca, da, pa, fa, oa}), 0);
        chk("rst_b", 32'({vb, cb, db, pb, fb, ob}), 0);
        chk("rst_c", 32'({vc, cc, dc, pc, fc, oc}), 0);

        send(0, 8'h55, 1'b0, -1, 1'b1);
        tick(2);
        chk("8n1_data", 32'(da), 32'h55);
        chk("8n1_flags", 32'({pa, fa}), 0);
        chk("8n1_count", 32'(ca), 1);
        pop1();
        tick(1);
        chk("8n1_valid", 32'(va), 0);

        send(1, 8'hA5, 1'b1, -1, 1'b1);
        tick(2);
        chk("par_bad_data", 32'(db), 32'hA5);
        chk("par_bad_perr", 32'(pb), 1);
        pop1();
        send(1, 8'hA5, 1'b0, -1, 1'b1);
        tick(2);
        chk("par_ok_perr", 32'(pb), 0);
        pop1();

        send(0, 8'h3C, 1'b0, 0, 1'b1);
        send(0, 8'hC3, 1'b0, -1, 1'b1);
        tick(2);
        chk("ferr_count", 32'(ca), 2);
        chk("ferr_head", 32'({fa, da}), 32'h13C);
        pop1();
        chk("ferr_next", 32'({fa, da}), 32'h0C3);
        pop1();
        tick(2 * P);

        drive(0, 1'b0);
        tick(3);
        drive(0, 1'b1);
        tick(2 * P);
        chk("glitch_count", 32'(ca), 0);
        chk("glitch_valid", 32'(va), 0);
        send(0, 8'h81, 1'b0, -1, 1'b1);
        tick(2);
        chk("glitch_after", 32'(da), 32'h81);
        pop1();

        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, -1, i <= 4);
        tick(2);
        chk("ovr_count", 32'(ca), 4);
        chk("ovr_flag", 32'(oa), 1);
        rdy = 1'b1;
        tick(6);
        rdy = 1'b0;
        chk("ovr_drained", 32'(va), 0);
        chk("ovr_sticky", 32'(oa), 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovr_clear", 32'(oa), 0);

        drive(2, 1'b0);
        tick(P);
        for (int i = 0; i < 4; i++) begin
            drive(2, 1'(i));
            tick(P);
        end
        drive(2, 1'b1);
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(12 * P);
        chk("rstmid_c", 32'({vc, cc, dc, pc, fc, oc}), 0);
        chk("rstmid_ab", 32'({va, vb, ca, cb}), 0);
        send(2, 8'h2A, 1'b0, -1, 1'b1);
        tick(2);
        chk("rstmid_next", 32'({fc, dc}), 32'h2A);
        pop1();

        rand_rdy = 1'b1;
        for (int w = 0; w < 3; w++) begin
            nsb = (w == 2) ? 2 : 1;
            repeat (15) begin
                d   = 8'($urandom);
                bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nsb - 1)) : -1;
                send(w, d, 1'($urandom_range(0, 1)), bad, 1'b1);
                tick((bad >= 0 ? P : 0) + int'($urandom_range(0, 3)));
            end
        end
        rand_rdy = 1'b0;
        tick(1);
        rdy = 1'b1;
        for (int k = 0; k < 200 && (qa.size() + qb.size() + qc.size()) != 0; k++)
            tick(1);
        rdy = 1'b0;
        chk("end_qa", 32'(qa.size()), 0);
        chk("end_qb", 32'(qb.size()), 0);
        chk("end_qc", 32'(qc.size()), 0);
        chk("end_valid", 32'({va, vb, vc}), 0);
        chk("end_overrun", 32'({oa, ob, oc}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Synthesizable, parametrised UART receiver that replaces the simulation-only mock receiver in the CPU's peripheral path. It oversamples the serial input on the system clock, detects start bits with glitch rejection, and collects 5–8 data bits LSB first. It then checks optional parity and 1 or 2 stop bits, and pushes each character with per-character error flags into an internal FIFO. The CPU-side UART register block drains the FIFO over a valid/ready handshake.

## Interface
- ClockFreqHz, 10000000 — system clock frequency.
- BaudRate, 9600 — line rate. Bit period is P = ClockFreqHz / BaudRate (integer division), and P must be ≥ 4.
- DataBitsSize, 8 — data bits per character, range 5..8.
- ParityEn, 0 — 1 enables the parity bit.
- ParityOdd, 0 — parity sense when ParityEn = 1: 0 = even, 1 = odd.
- StopBitsSize, 1 — number of stop bits, 1 or 2.
- FifoDepth, 16 — number of FIFO entries; must be a power of 2 and ≥ 2.
- clk  in  1  system clock. This is the block's only clock.
- rst  in  1  reset, synchronous and active-high.
- rx_sig  in  1  asynchronous serial input; idle level is 1.
- rx_data  out  DataBitsSize  character at the FIFO head.
- rx_perr  out  1  parity error flag of the head entry (always 0 when ParityEn = 0).
- rx_ferr  out  1  framing error flag of the head entry.
- rx_valid  out  1  FIFO is non-empty.
- rx_ready  in  1  consumer accepts the head entry; a pop occurs when rx_valid && rx_ready.
- fifo_count  out  $clog2(FifoDepth+1)  current number of FIFO entries.
- overrun  out  1  sticky flag: a character was dropped because the FIFO was full.
- clr_overrun  in  1  clears overrun.

## Operation
- **Input synchronizer.** rx_sig passes through a 2-flop synchronizer; its output is called rxs. Both flops reset to 1.
- **Counters.** A bit-timer counter cnt increments every cycle. A data index idx counts received bits.
- **IDLE.** When rxs == 0, go to START and set cnt = 0.
- **START.** When cnt == P/2−1, sample rxs.
  - rxs == 1: glitch; return to IDLE and record nothing.
  - rxs == 0: set cnt = 0, idx = 0, go to DATA.
- **DATA.** When cnt == P−1, store rxs into shift[idx], increment idx, set cnt = 0. After bit DataBitsSize−1 is stored, go to PARITY if ParityEn, otherwise go to STOP.
- **PARITY.** When cnt == P−1, sample the parity bit.
  - perr = (XOR of the data bits ^ parity bit) != ParityOdd.
  - Set cnt = 0 and go to STOP.
- **STOP.** When cnt == P−1, sample the stop bit; if it is 0, set ferr = 1. After StopBitsSize stop samples, finish the frame:
  - Push the entry {ferr, perr, data}; the data is still stored when ferr = 1.
  - Go to IDLE on the same edge. A start bit arriving immediately after the stop sample is therefore detected.
- **FIFO.** First-word-fall-through. rx_data, rx_perr and rx_ferr are 0 whenever the FIFO is empty.
- **Push into a full FIFO.**
  - If a pop happens in the same cycle, both the push and the pop occur and fifo_count is unchanged.
  - Otherwise the new character is discarded, the FIFO contents are unchanged, and overrun is set.
- **Overrun clear.** If overrun is set and clr_overrun is asserted in the same cycle, set wins.
- **Empty FIFO.** A pop while empty is impossible, because rx_valid = 0 when the FIFO is empty.
- **Pointers.** FIFO pointers are $clog2(FifoDepth) bits wide and wrap naturally. fifo_count is computed from the pointers plus an extra wrap bit.

## Timing
- **Reset values (rst = 1 at a clk edge).**
  - State = IDLE; cnt, idx, perr and ferr = 0.
  - Synchronizer = 1.
  - FIFO emptied: fifo_count = 0, rx_valid = 0, rx_data, rx_perr and rx_ferr = 0.
  - overrun = 0.
  - A frame in progress is abandoned with no partial push.
- **Start detection.** A falling edge on rx_sig is visible on rxs 2 cycles later.
- **Sample points.** The start bit is sampled about P/2 cycles after detection. Each later sample is P cycles after the previous one, so every sample falls at mid-bit.
- **Push timing.** The push happens on the edge that samples the final stop bit. rx_valid is 1 in the following cycle.
- **Pop timing.** A pop on edge N updates rx_data and fifo_count after edge N, i.e. in cycle N+1.
- **Latency.** From the rx_sig start edge to rx_valid is about 2 + P/2 + P·(DataBitsSize + ParityEn + StopBitsSize) + 1 cycles.

## Structure
- **Package uart_pkg.** Contains:
  - the enum uart_rx_state_e {IDLE, START, DATA, PARITY, STOP};
  - the function calc_parity(data, odd);
  - the localparam-style helper for the bit period P.
- **Sub-module sync_fifo.** Parameters Width and Depth. Ports: push, pop, wdata, rdata, full, empty, count. uart_rx instantiates it with Width = DataBitsSize + 2.
- **Receive logic.** The FSM and the synchronizer live in uart_rx.

## Test plan
All scenarios use ClockFreqHz = 10000000 and BaudRate = 1000000 (P = 10), with DataBitsSize = 8, StopBitsSize = 1 and FifoDepth = 4 unless stated otherwise.
- **8N1, 0x55.** Drive 0x55 with rx_ready = 0 → rx_data = 0x55, rx_perr = 0, rx_ferr = 0, fifo_count = 1. Pulse rx_ready → rx_valid = 0.
- **Even parity, bad parity bit.** ParityEn = 1, ParityOdd = 0. Send 0xA5 with parity bit 1 → rx_data = 0xA5, rx_perr = 1. Resend with parity bit 0 → rx_perr = 0.
- **Framing error, back-to-back.** Send 0x3C with the stop bit driven 0 → rx_ferr = 1, rx_data = 0x3C. Send 0xC3 back-to-back → received with rx_ferr = 0.
- **Glitch rejection.** Drive rx_sig low for 3 cycles, then high → no push and fifo_count stays 0. A valid 0x81 sent afterwards is received correctly.
- **Overrun.** Send 5 characters 0x01..0x05 with rx_ready = 0 → fifo_count = 4, overrun = 1, and the pops return 0x01..0x04. Then assert clr_overrun → overrun = 0.
- **Reset mid-frame.** Assert rst during data bit 4 → all outputs return to reset values and nothing is pushed. With DataBitsSize = 7 and StopBitsSize = 2, a following frame 0x2A is received correctly.
